// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and FSM state encoding for the register-file scan/write initiator.
// Optional macro REGFILE_CTRL_READBACK_EN adds the readback-verify states.
package regfile_ctrl_pkg;

    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int N_REGS = 16;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
`ifdef REGFILE_CTRL_READBACK_EN
        RB_WAIT,
        RB_CHK,
`endif
        RD_ADDR,
        RD_WAIT,
        RD_CAP
    } state_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Host-side bundle of regfile_ctrl: single-word write handshake and full-scan stream.
// The host (control FSM) uses the master modport, regfile_ctrl uses the slave modport.
interface regfile_ctrl_if;
    import regfile_ctrl_pkg::*;

    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          wr_err;
    logic          scan_start;
    logic          scan_valid;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_data;
    logic          scan_done;
    logic          busy;

    modport master (
        output wr_req, wr_addr, wr_data, scan_start,
        input  wr_ack, wr_err, scan_valid, scan_addr, scan_data, scan_done, busy
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, scan_start,
        output wr_ack, wr_err, scan_valid, scan_addr, scan_data, scan_done, busy
    );

endinterface

// File: rtl/regfile_ctrl.sv
// Register-file initiator: merges host single-word writes with a sequential full scan.
// Define REGFILE_CTRL_READBACK_EN to verify each write by reading it back (sets wr_err).
//
// state   | meaning
// IDLE    | nothing in flight, waiting for wr_req or scan_start
// WRITE   | one-cycle register-file write of the latched host word
// RB_WAIT | (readback) address the written entry, wait for registered read
// RB_CHK  | (readback) compare read data against written word, ack
// RD_ADDR | drive scan index onto rf_address
// RD_WAIT | register file read latency
// RD_CAP  | capture entry, emit scan_valid, advance or finish
module regfile_ctrl
    import regfile_ctrl_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    regfile_ctrl_if.slave bus,
    output logic [AW-1:0] rf_address,
    output logic          rf_en_write,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_data_out
);

    state_t        state;
    logic [AW-1:0] idx;
    logic          scan_on;
    logic          accept_ok;

`ifdef REGFILE_CTRL_READBACK_EN
    logic [AW-1:0] wa_q;
    logic [DW-1:0] wd_q;
`else
    assign bus.wr_err = 1'b0;
`endif

    // A request still held during its own ack cycle must not be accepted twice.
    assign accept_ok = bus.wr_req && !bus.wr_ack;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            scan_on        <= 1'b0;
            rf_address     <= '0;
            rf_en_write    <= 1'b0;
            rf_data_in     <= '0;
            bus.wr_ack     <= 1'b0;
            bus.scan_valid <= 1'b0;
            bus.scan_addr  <= '0;
            bus.scan_data  <= '0;
            bus.scan_done  <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef REGFILE_CTRL_READBACK_EN
            bus.wr_err     <= 1'b0;
            wa_q           <= '0;
            wd_q           <= '0;
`endif
        end else begin
            rf_en_write    <= 1'b0;
            bus.wr_ack     <= 1'b0;
            bus.scan_valid <= 1'b0;
            bus.scan_done  <= 1'b0;
`ifdef REGFILE_CTRL_READBACK_EN
            bus.wr_err     <= 1'b0;
`endif
            if (bus.scan_start && !scan_on)
                scan_on <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept_ok) begin
                        state       <= WRITE;
                        bus.busy    <= 1'b1;
                        rf_address  <= bus.wr_addr;
                        rf_en_write <= 1'b1;
                        rf_data_in  <= bus.wr_data;
`ifdef REGFILE_CTRL_READBACK_EN
                        wa_q        <= bus.wr_addr;
                        wd_q        <= bus.wr_data;
`endif
                    end else if (bus.scan_start || scan_on) begin
                        state      <= RD_ADDR;
                        bus.busy   <= 1'b1;
                        rf_address <= idx;
                    end
                end

                WRITE: begin
`ifdef REGFILE_CTRL_READBACK_EN
                    state      <= RB_WAIT;
                    rf_address <= wa_q;
`else
                    bus.wr_ack <= 1'b1;
                    if (scan_on || bus.scan_start) begin
                        state      <= RD_ADDR;
                        rf_address <= idx;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
`endif
                end

`ifdef REGFILE_CTRL_READBACK_EN
                RB_WAIT: state <= RB_CHK;

                RB_CHK: begin
                    bus.wr_ack <= 1'b1;
                    bus.wr_err <= (rf_data_out != wd_q);
                    if (scan_on || bus.scan_start) begin
                        state      <= RD_ADDR;
                        rf_address <= idx;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
`endif

                RD_ADDR: state <= RD_WAIT;

                RD_WAIT: state <= RD_CAP;

                RD_CAP: begin
                    bus.scan_valid <= 1'b1;
                    bus.scan_addr  <= idx;
                    bus.scan_data  <= rf_data_out;
                    if (idx == LAST_IDX) begin
                        bus.scan_done <= 1'b1;
                        scan_on       <= 1'b0;
                        idx           <= '0;
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                        // Host writes slot in only between entries; the scan resumes at idx+1.
                        if (accept_ok) begin
                            state       <= WRITE;
                            rf_address  <= bus.wr_addr;
                            rf_en_write <= 1'b1;
                            rf_data_in  <= bus.wr_data;
`ifdef REGFILE_CTRL_READBACK_EN
                            wa_q        <= bus.wr_addr;
                            wd_q        <= bus.wr_data;
`endif
                        end else begin
                            state      <= RD_ADDR;
                            rf_address <= idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
